// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer: ROM-driven ALU opcode sequencer with 4x8 register file.
// Optional EXEC timeout abort when SEQ_TIMEOUT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [2:0]        opcode,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_req,
  input  logic              alu_done,
  input  logic [7:0]        alu_result,
  output logic              cmp_flag,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_WB    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] pc_next;
  logic [1:0]        rd_q;
  logic [7:0]        res_q;
  logic [7:0]        regs [4];

  assign pc_next  = pc + 1'b1;
  assign rom_addr = pc;

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      len_q    <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      opcode   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_req  <= 1'b0;
      cmp_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef SEQ_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      alu_req <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc    <= '0;
            len_q <= prog_len;
            error <= 1'b0;
            if (prog_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_FETCH;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          // Operands are decoded straight off the ROM word so alu_req lands in ISSUE.
          rd_q    <= rom_data[12:11];
          opcode  <= rom_data[15:13];
          alu_a   <= regs[rom_data[10:9]];
          alu_b   <= rom_data[8] ? rom_data[7:0] : regs[rom_data[7:6]];
          alu_req <= 1'b1;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_EXEC;
`ifdef SEQ_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        S_EXEC: begin
          if (alu_done) begin
            res_q <= alu_result;
            state <= S_WB;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            state <= S_DONE;
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_WB: begin
          if (opcode == OP_CMP) cmp_flag <= res_q[0];
          else                  regs[rd_q] <= res_q;
          pc <= pc_next;
          if (pc_next == len_q) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  prog_len = '0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [2:0]  opcode;
  logic [7:0]  alu_a, alu_b;
  logic        alu_req;
  logic        alu_done;
  logic [7:0]  alu_result;
  logic        cmp_flag, busy, done, error;

  logic        done_m = 1'b0;
  logic        spur_done = 1'b0;
  logic        alu_mute = 1'b0;
  int          alu_delay = 1;
  logic [7:0]  res_t;
  logic [15:0] rom [256];
  logic [18:0] issue_log [64];
  int          n_issued = 0;
  int          errors = 0;
  int          checks = 0;

  assign alu_done = done_m | spur_done;

  alu_op_sequencer #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .opcode(opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_req(alu_req), .alu_done(alu_done),
    .alu_result(alu_result), .cmp_flag(cmp_flag), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [15:0] ins_i(logic [2:0] op, logic [1:0] rd, logic [1:0] ra, logic [7:0] imm);
    return {op, rd, ra, 1'b1, imm};
  endfunction

  function automatic logic [15:0] ins_r(logic [2:0] op, logic [1:0] rd, logic [1:0] ra, logic [1:0] rb);
    return {op, rd, ra, 1'b0, rb, 6'b0};
  endfunction

  function automatic logic [7:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b111:  return {7'b0, a == b};
      default: return a ^ b;
    endcase
  endfunction

  // ALU model: logs each request, answers alu_delay cycles after the req cycle.
  initial begin
    alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_req === 1'b1) begin
        issue_log[n_issued] = {opcode, alu_a, alu_b};
        n_issued = n_issued + 1;
        res_t = alu_fn(opcode, alu_a, alu_b);
        if (!alu_mute) begin
          repeat (alu_delay) @(posedge clk);
          #1 done_m = 1'b1; alu_result = res_t;
          @(posedge clk);
          #1 done_m = 1'b0;
        end
      end
    end
  end

  task automatic run_prog(input logic [7:0] len, output int cycles);
    int n = 0;
    @(negedge clk);
    prog_len = len;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    cycles = (n >= 200) ? -1 : n;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({opcode, alu_a, alu_b} !== 19'h0) begin errors++; $display("FAIL reset_operands: got %h want 0", {opcode, alu_a, alu_b}); end
    checks++; if ({alu_req, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {alu_req, busy, done}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
    checks++; if (cmp_flag !== 1'b0) begin errors++; $display("FAIL reset_cmp_flag: got %b want 0", cmp_flag); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b want 00", {busy, done}); end
  endtask

  task automatic test_program();
    logic [18:0] exp [3];
    int cyc;
    int base = n_issued;
    exp[0] = {3'b000, 8'h00, 8'h05};
    exp[1] = {3'b000, 8'h05, 8'h03};
    exp[2] = {3'b001, 8'h08, 8'h05};
    rom[0] = ins_i(3'b000, 2'd1, 2'd0, 8'h05);
    rom[1] = ins_i(3'b000, 2'd2, 2'd1, 8'h03);
    rom[2] = ins_r(3'b001, 2'd3, 2'd2, 2'd1);
    run_prog(8'd3, cyc);
    checks++; if (cyc !== 15) begin errors++; $display("FAIL prog_cycles: got %0d want 15", cyc); end
    checks++; if (n_issued - base !== 3) begin errors++; $display("FAIL prog_issue_count: got %0d want 3", n_issued - base); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (issue_log[base+i] !== exp[i]) begin errors++; $display("FAIL prog_issue%0d: got %h want %h", i, issue_log[base+i], exp[i]); end
    end
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL prog_done_state: got %b want 01", {busy, done}); end
  endtask

  task automatic test_compare();
    int cyc;
    int base = n_issued;
    rom[0] = ins_i(3'b111, 2'd1, 2'd3, 8'h03);
    rom[1] = ins_i(3'b000, 2'd0, 2'd1, 8'h00);
    run_prog(8'd2, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL cmp_cycles: got %0d want 10", cyc); end
    checks++; if (cmp_flag !== 1'b1) begin errors++; $display("FAIL cmp_flag: got %b want 1", cmp_flag); end
    checks++; if (issue_log[base] !== {3'b111, 8'h03, 8'h03}) begin errors++; $display("FAIL cmp_issue: got %h want %h", issue_log[base], {3'b111, 8'h03, 8'h03}); end
    checks++; if (issue_log[base+1] !== {3'b000, 8'h05, 8'h00}) begin errors++; $display("FAIL cmp_no_write: got %h want %h", issue_log[base+1], {3'b000, 8'h05, 8'h00}); end
  endtask

  task automatic test_slow_alu();
    int n = 0;
    int req_cycles = 0;
    int unstable = 0;
    bit seen = 0;
    logic [18:0] snap = '0;
    alu_delay = 7;
    rom[0] = ins_r(3'b000, 2'd2, 2'd2, 2'd1);
    @(negedge clk);
    prog_len = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (alu_req) req_cycles++;
      if (alu_req && !seen) begin
        seen = 1;
        snap = {opcode, alu_a, alu_b};
      end else if (seen && !done && {opcode, alu_a, alu_b} !== snap) begin
        unstable++;
      end
    end
    alu_delay = 1;
    checks++; if (n !== 11) begin errors++; $display("FAIL slow_cycles: got %0d want 11", n); end
    checks++; if (req_cycles !== 1) begin errors++; $display("FAIL slow_req_width: got %0d want 1", req_cycles); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL slow_stability: got %0d changes want 0", unstable); end
    checks++; if (snap !== {3'b000, 8'h08, 8'h05}) begin errors++; $display("FAIL slow_operands: got %h want %h", snap, {3'b000, 8'h08, 8'h05}); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    int cyc;
    int base = n_issued;
    int base2;
    alu_delay = 7;
    rom[0] = ins_i(3'b000, 2'd0, 2'd2, 8'h00);
    rom[1] = ins_i(3'b000, 2'd1, 2'd1, 8'h01);
    @(negedge clk);
    prog_len = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n_issued < base + 2 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    checks++; if (n_issued - base !== 2) begin errors++; $display("FAIL arst_reach_exec: got %0d issues want 2", n_issued - base); end
    checks++; if (issue_log[base] !== {3'b000, 8'h0D, 8'h00}) begin errors++; $display("FAIL arst_first_run: got %h want %h", issue_log[base], {3'b000, 8'h0D, 8'h00}); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({rom_addr, opcode, alu_a, alu_b, alu_req, cmp_flag, busy, done, error} !== 32'h0) begin
      errors++; $display("FAIL arst_outputs: got %h want 0", {rom_addr, opcode, alu_a, alu_b, alu_req, cmp_flag, busy, done, error});
    end
    @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL arst_idle: got %b want 00", {busy, done}); end
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    alu_delay = 1;
    base2 = n_issued;
    run_prog(8'd2, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL arst_rerun_cycles: got %0d want 10", cyc); end
    checks++; if (issue_log[base2] !== {3'b000, 8'h00, 8'h00}) begin errors++; $display("FAIL arst_regs_cleared: got %h want %h", issue_log[base2], {3'b000, 8'h00, 8'h00}); end
    checks++; if (issue_log[base2+1] !== {3'b000, 8'h00, 8'h01}) begin errors++; $display("FAIL arst_rerun_issue1: got %h want %h", issue_log[base2+1], {3'b000, 8'h00, 8'h01}); end
  endtask

  task automatic test_spurious();
    int n = 0;
    int base = n_issued;
    rom[0] = ins_i(3'b000, 2'd2, 2'd1, 8'h02);
    rom[1] = ins_r(3'b000, 2'd3, 2'd2, 2'd1);
    @(negedge clk);
    prog_len = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    spur_done = 1'b1;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
      spur_done = 1'b0;
      if (n == 2) begin start = 1'b1; prog_len = 8'd5; end
      if (n == 3) start = 1'b0;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL spur_cycles: got %0d want 10", n); end
    checks++; if (n_issued - base !== 2) begin errors++; $display("FAIL spur_issue_count: got %0d want 2", n_issued - base); end
    checks++; if (issue_log[base] !== {3'b000, 8'h01, 8'h02}) begin errors++; $display("FAIL spur_issue0: got %h want %h", issue_log[base], {3'b000, 8'h01, 8'h02}); end
    checks++; if (issue_log[base+1] !== {3'b000, 8'h03, 8'h01}) begin errors++; $display("FAIL spur_raw_issue1: got %h want %h", issue_log[base+1], {3'b000, 8'h03, 8'h01}); end
  endtask

  task automatic test_zero_len();
    int cyc;
    int base = n_issued;
    run_prog(8'd0, cyc);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL zero_len_cycles: got %0d want 0", cyc); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL zero_len_state: got %b want 01", {busy, done}); end
    checks++; if (n_issued - base !== 0) begin errors++; $display("FAIL zero_len_issues: got %0d want 0", n_issued - base); end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int k = 0;
    int cyc;
    alu_mute = 1'b1;
    rom[0] = ins_i(3'b000, 2'd0, 2'd0, 8'h01);
    @(negedge clk);
    prog_len = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!alu_req && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    while (!done && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    alu_mute = 1'b0;
    checks++; if (k !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", k); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
    run_prog(8'd1, cyc);
    checks++; if ({error, cyc} !== {1'b0, 32'd5}) begin errors++; $display("FAIL timeout_clear: got err=%b cyc=%0d want err=0 cyc=5", error, cyc); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    test_reset();
    test_program();
    test_compare();
    test_slow_alu();
    test_async_reset();
    test_spurious();
    test_zero_len();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`else
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_tied_low: got %b want 0", error); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Produces the 3-bit opcode stream that the CPU's opcode-to-ALU-select decode consumes.
- Fetches 16-bit instruction words from program ROM, extracts opcode/register/immediate fields, reads operands from an internal 4x8 register file, and issues one ALU operation at a time via req/done handshake.
- Writes results back to the register file; compare results go to a flag register instead.

Parameters:
- ADDR_W, 8, program ROM address width
- TIMEOUT, 16, max cycles waiting for alu_done (used only with optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins execution at pc=0 (ignored unless IDLE or DONE)
- prog_len  input  ADDR_W  number of instructions; execution stops after pc reaches prog_len
- rom_addr  output  ADDR_W  ROM read address
- rom_data  input  16  ROM word, valid exactly 1 cycle after rom_addr presented
- opcode  output  3  ALU opcode, held stable from alu_req until alu_done
- alu_a  output  8  operand A, same stability rule
- alu_b  output  8  operand B, same stability rule
- alu_req  output  1  one-cycle pulse starting an operation
- alu_done  input  1  one-cycle pulse; alu_result valid this cycle
- alu_result  input  8  ALU result
- cmp_flag  output  1  registered bit0 of last compare (opcode 3'b111) result
- busy  output  1  high in every state except IDLE/DONE
- done  output  1  high in DONE
- error  output  1  timeout abort indicator (0 unless feature compiled in)

Behaviour:
- Instruction format: [15:13] opcode, [12:11] rd, [10:9] ra, [8] imm_sel, [7:0] imm8 when imm_sel=1, else [7:6] rb.
- alu_a = reg[ra]; alu_b = imm_sel ? imm8 : reg[rb].
- Reset: all outputs 0, pc=0, regfile all 0x00, cmp_flag=0, state IDLE.
- States:
  - IDLE -> FETCH on start. If prog_len=0, go straight to DONE.
  - FETCH: drive rom_addr=pc -> WAIT.
  - WAIT: latch rom_data into instruction register -> ISSUE.
  - ISSUE: drive opcode/alu_a/alu_b, pulse alu_req for 1 cycle -> EXEC.
  - EXEC: wait for alu_done. alu_done in same cycle as leaving ISSUE is not possible, because ISSUE lasts exactly 1 cycle. On alu_done -> WB.
  - WB: if opcode!=3'b111, reg[rd]<=alu_result, else cmp_flag<=alu_result[0]. Then pc<=pc+1. If pc+1==prog_len -> DONE, else FETCH.
  - DONE: done=1, busy=0; start -> FETCH with pc reset to 0. Regfile and cmp_flag are retained across restarts.
- Latency: minimum 5 cycles per instruction (FETCH, WAIT, ISSUE, EXEC with immediate done, WB).
- pc width ADDR_W; wrap cannot occur since prog_len bounds execution. prog_len is sampled at start and held in a register.
- start while busy: ignored. Spurious alu_done outside EXEC: ignored.
- Async reset mid-operation: immediate return to IDLE, regfile cleared, alu_req deasserted.
- Register read-after-write: WB completes before next FETCH, so the next instruction sees the updated value.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in EXEC. If TIMEOUT cycles elapse without alu_done, go to DONE with error=1, no writeback, pc unchanged. error clears on next start.
- Not defined: EXEC waits indefinitely; error tied 0.

Test Plan:
- Reset, start with prog_len=3, ROM {add r1,r0,imm 0x05; add r2,r1,imm 0x03; sub r3,r2,r1}, ALU model done 1 cycle after req -> opcodes 000,000,001 issued; reg r1=0x05, r2=0x08, r3=0x03; done after 15 cycles.
- Compare 3'b111 with ALU returning 0x01 -> cmp_flag=1, no regfile write (r0..r3 unchanged).
- ALU model delays alu_done 7 cycles (mul/div) -> opcode/alu_a/alu_b stable throughout EXEC, alu_req exactly 1 cycle high.
- Assert rst_n low during EXEC of instruction 2 -> all outputs 0, state IDLE next cycle; subsequent start reruns from pc=0.
- start pulsed while busy, and alu_done pulsed during FETCH -> no effect on pc or sequence.
- With SEQ_TIMEOUT_EN, TIMEOUT=16, ALU never responds -> error=1, done=1 at 16 cycles after alu_req; next start clears error.
